// File: rtl/loop_stack_unit.sv
// Bracket-matching engine: return-address stack for nested [ ] loops plus a
// forward-skip mode that walks over a loop body entered with a zero accumulator.
module loop_stack_unit #(
  parameter int PC_WIDTH      = 8,
  parameter int DEPTH         = 16,
  parameter int SKIP_NEST_MAX = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  input  logic                         is_open,
  input  logic                         is_close,
  input  logic                         acc_zero,
  input  logic [PC_WIDTH-1:0]          pc_next,
  output logic                         jump_valid,
  output logic [PC_WIDTH-1:0]          jump_pc,
  output logic                         skipping,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = (SKIP_NEST_MAX > 0) ? $clog2(SKIP_NEST_MAX+1) : 1;

  typedef enum logic [1:0] {RUN, SKIP, FAULT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] stack [DEPTH];
  logic [NW-1:0]       nest;

  logic          open_cmd, close_cmd, empty, full, push;
  logic [DW-1:0] top_cnt;
  logic [AW-1:0] top_idx, wr_idx;

  // Both bracket flags together is an illegal encoding and acts as a no-op.
  assign open_cmd  = instr_valid && is_open && !is_close;
  assign close_cmd = instr_valid && is_close && !is_open;
  assign empty     = (depth == '0);
  assign full      = (depth == DW'(DEPTH));
  assign top_cnt   = depth - DW'(1);
  assign top_idx   = top_cnt[AW-1:0];
  assign wr_idx    = depth[AW-1:0];
  assign push      = (state == RUN) && open_cmd && !acc_zero && !full;

  assign jump_valid = (state == RUN) && close_cmd && !acc_zero && !empty;
  assign jump_pc    = empty ? '0 : stack[top_idx];
  assign skipping   = (state == SKIP);

  // Entries are never read while unoccupied, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      depth     <= '0;
      nest      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (open_cmd) begin
            if (acc_zero) begin
              state <= SKIP;
              nest  <= '0;
            end else if (full) begin
              overflow <= 1'b1;
              state    <= FAULT;
            end else begin
              depth <= depth + DW'(1);
            end
          end else if (close_cmd) begin
            if (empty) begin
              underflow <= 1'b1;
              state     <= FAULT;
            end else if (acc_zero) begin
              depth <= depth - DW'(1);
            end
          end
        end
        SKIP: begin
          if (open_cmd) begin
            if (nest == NW'(SKIP_NEST_MAX)) begin
              overflow <= 1'b1;
              state    <= FAULT;
            end else begin
              nest <= nest + NW'(1);
            end
          end else if (close_cmd) begin
            // The matching ] is consumed here: no pop, no jump.
            if (nest == '0) state <= RUN;
            else            nest  <= nest - NW'(1);
          end
        end
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_stack_unit.sv
// Scoreboarded bench: driver runs a queue-based reference model and pushes
// expected outputs; an independent monitor pops and compares each cycle.
module tb_loop_stack_unit;
  localparam int PW = 8;
  localparam int DP = 4;
  localparam int NM = 3;
  localparam int DW = $clog2(DP+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0, is_open = 1'b0, is_close = 1'b0, acc_zero = 1'b0;
  logic [PW-1:0] pc_next = '0;
  logic          jump_valid, skipping, overflow, underflow;
  logic [PW-1:0] jump_pc;
  logic [DW-1:0] depth;

  loop_stack_unit #(.PC_WIDTH(PW), .DEPTH(DP), .SKIP_NEST_MAX(NM)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_open(is_open),
    .is_close(is_close), .acc_zero(acc_zero), .pc_next(pc_next),
    .jump_valid(jump_valid), .jump_pc(jump_pc), .skipping(skipping),
    .depth(depth), .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  typedef struct {
    int jv; int jpc; int dep; int skp; int ovf; int unf;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain queue of return addresses and a mode number.
  localparam int M_RUN = 0, M_SKIP = 1, M_FAULT = 2;
  int m_stk[$];
  int m_mode, m_nest, m_ovf, m_unf;

  function automatic void model_reset();
    m_stk.delete();
    m_mode = M_RUN; m_nest = 0; m_ovf = 0; m_unf = 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input bit v, input bit o, input bit c, input bit az, input int pc);
    exp_t e;
    bit op, cl;
    @(negedge clk);
    reset = 1'b0; instr_valid = v; is_open = o; is_close = c; acc_zero = az;
    pc_next = PW'(pc);
    op = v && o && !c;
    cl = v && c && !o;
    e.jv  = (m_mode == M_RUN && cl && !az && m_stk.size() > 0) ? 1 : 0;
    e.jpc = (m_stk.size() > 0) ? m_stk[$] : 0;
    e.dep = m_stk.size();
    e.skp = (m_mode == M_SKIP) ? 1 : 0;
    e.ovf = m_ovf; e.unf = m_unf;
    exp_q.push_back(e);
    if (m_mode == M_RUN) begin
      if (op) begin
        if (az) begin m_mode = M_SKIP; m_nest = 0; end
        else if (m_stk.size() == DP) begin m_ovf = 1; m_mode = M_FAULT; end
        else m_stk.push_back(pc & 8'hff);
      end else if (cl) begin
        if (m_stk.size() == 0) begin m_unf = 1; m_mode = M_FAULT; end
        else if (az) void'(m_stk.pop_back());
      end
    end else if (m_mode == M_SKIP) begin
      if (op) begin
        if (m_nest == NM) begin m_ovf = 1; m_mode = M_FAULT; end
        else m_nest++;
      end else if (cl) begin
        if (m_nest == 0) m_mode = M_RUN;
        else m_nest--;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      instr_valid = 1'($urandom_range(0, 1));
      is_open = 1'($urandom_range(0, 1));
      is_close = 1'($urandom_range(0, 1));
      acc_zero = 1'($urandom_range(0, 1));
    end
    model_reset();
  endtask

  // Monitor: samples outputs between the driving edge and the next active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("jump_valid", int'(jump_valid), e.jv);
        chk("jump_pc",    int'(jump_pc),    e.jpc);
        chk("depth",      int'(depth),      e.dep);
        chk("skipping",   int'(skipping),   e.skp);
        chk("overflow",   int'(overflow),   e.ovf);
        chk("underflow",  int'(underflow),  e.unf);
      end
    end
  end

  initial begin
    model_reset();
    do_reset(2);
    // Single loop: push, taken ], exiting ]
    issue(1, 1, 0, 0, 'h05); issue(1, 0, 1, 0, 'h33); issue(1, 0, 1, 1, 'h34);
    issue(0, 0, 0, 0, 'h00);
    // Nesting
    issue(1, 1, 0, 0, 'h02); issue(1, 1, 0, 0, 'h04); issue(1, 1, 0, 0, 'h06);
    issue(1, 0, 1, 1, 'h00); issue(1, 0, 1, 1, 'h00); issue(1, 0, 1, 0, 'h00);
    issue(1, 0, 1, 1, 'h00); issue(1, 1, 1, 0, 'h77); issue(0, 0, 0, 0, 'h00);
    // Skip over [ [ ] + ] ] then a taken ] on the prior top
    issue(1, 1, 0, 0, 'h10); issue(1, 1, 0, 1, 'h20);
    issue(1, 1, 0, 0, 'h21); issue(1, 1, 0, 1, 'h22); issue(1, 0, 1, 0, 'h23);
    issue(1, 0, 0, 0, 'h24); issue(1, 0, 1, 1, 'h25); issue(1, 0, 1, 0, 'h26);
    issue(1, 0, 1, 0, 'h27); issue(1, 0, 1, 1, 'h28); issue(0, 0, 0, 0, 'h00);
    // Overflow at full, then FAULT ignores ]
    for (int i = 0; i < 5; i++) issue(1, 1, 0, 0, 'h40 + i);
    issue(1, 0, 1, 0, 'h00); issue(1, 0, 1, 1, 'h00);
    do_reset(1); issue(0, 0, 0, 0, 'h00);
    // Underflow, commands ignored afterwards
    issue(1, 0, 1, 0, 'h00); issue(1, 1, 0, 0, 'h50); issue(1, 1, 0, 1, 'h51);
    issue(1, 0, 1, 0, 'h00);
    do_reset(1); issue(0, 0, 0, 0, 'h00);
    // Reset mid-SKIP with nest=2, depth=3
    issue(1, 1, 0, 0, 'h61); issue(1, 1, 0, 0, 'h62); issue(1, 1, 0, 0, 'h63);
    issue(1, 1, 0, 1, 'h64); issue(1, 1, 0, 0, 'h65); issue(1, 1, 0, 0, 'h66);
    do_reset(1); issue(0, 0, 0, 0, 'h00); issue(1, 0, 1, 0, 'h00);
    issue(0, 0, 0, 0, 'h00);
    do_reset(1);
    // Nest counter overflow while skipping
    issue(1, 1, 0, 1, 'h70);
    for (int i = 0; i < NM + 1; i++) issue(1, 1, 0, 0, 'h71);
    issue(1, 0, 1, 0, 'h00);
    do_reset(1);
    // Pop at full then push: legal
    for (int i = 0; i < DP; i++) issue(1, 1, 0, 0, 'h80 + i);
    issue(1, 0, 1, 1, 'h00); issue(1, 1, 0, 0, 'h90); issue(1, 0, 1, 0, 'h00);
    issue(0, 0, 0, 0, 'h00);
    // Randomised traffic with periodic resets to escape FAULT
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset($urandom_range(1, 2));
      else begin
        int k;
        bit o, c;
        k = $urandom_range(0, 9);
        o = (k < 4) || (k == 9);
        c = (k >= 4 && k < 8) || (k == 9);
        issue(($urandom_range(0, 7) != 0), o, c,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 255));
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    #4;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
